frog_log_rider: RTL and testbench
=================================

# frog_log_rider

Carries the frog along with a moving log in one river lane. Sits between a log mover and the frog controller. It watches the log's position and its one-cycle `moved` strobe, and decides whether a frog that has just landed is on the log. While the frog rides, it turns each log step into a one-cycle push request to the frog. It signals a splash when the frog lands in the water or is carried off the lane.

## Interface
- `LOG_LEN`, default 64: log length in pixels; `logX` is the log's left edge.
- `FROG_W`, default 16: frog width in pixels; `frogX` is the frog's left edge.
- `LANE_RIGHT`, default 431: rightmost pixel a frog's right edge may occupy.
- `frame_clk`, input, 1: clock for all state.
- `Reset`, input, 1: synchronous, active-high reset, sampled on the `frame_clk` rising edge.
- `logX`, input, 10: log left-edge X.
- `logY`, input, 10: log lane Y.
- `logMoved`, input, 1: one-cycle strobe; the log has just moved +1 in X or wrapped.
- `frogX`, input, 10: frog left-edge X.
- `frogY`, input, 10: frog Y.
- `frogLanded`, input, 1: one-cycle strobe; a frog hop has completed.
- `frogHopping`, input, 1: level; a frog hop is in progress.
- `respawn`, input, 1: one-cycle strobe; the frog has been re-placed at the start.
- `push`, output, 1: one-cycle request to the frog controller to increment X by 1.
- `riding`, output, 1: level; the frog is on this log.
- `splash`, output, 1: one-cycle strobe; the frog has died in this lane.
- `dead`, output, 1: level; high from `splash` until `respawn`.

## Operation
- FSM states: IDLE, CHECK, RIDE, DEAD.
- Reset values: state IDLE; `push`, `riding`, `splash`, `dead` all 0. All outputs are registered.
- IDLE:
  - `frogLanded` && `frogY == logY` → CHECK, and latch `frogX`, `logX`.
  - Any other input is ignored.
- CHECK, one cycle:
  - Frog centre `cx = frogX + FROG_W/2`, computed at 11 bits.
  - On-log test: `logX <= cx <= logX + LOG_LEN - 1`, both sides at 11 bits, with no 10-bit wrap.
  - Pass → RIDE, `riding` = 1.
  - Fail → DEAD, `splash` pulse.
- RIDE:
  - `logMoved` with `logX` less than the previous `logX` (a wrap) → DEAD, `splash` pulse, `riding` = 0, no `push`.
  - `logMoved` with `frogX + FROG_W` (11-bit) greater than `LANE_RIGHT` → DEAD, `splash` pulse, no `push`.
  - Any other `logMoved` → `push` pulse.
  - `frogHopping` high → IDLE, `riding` = 0. This takes priority over `logMoved` in the same cycle.
- DEAD: `dead` = 1. Held until `respawn` → IDLE, `dead` = 0.
- `respawn` in any state → IDLE, and every output clears on the next edge.
- Previous-`logX` register: updated every cycle `logMoved` is high, in every state.
- `frogLanded` and `logMoved` in the same IDLE cycle: the landing is evaluated against the `logX` latched that cycle, i.e. the pre-move value. The move itself produces no push.

## Timing
- `frogLanded` at edge t → CHECK at t+1 → `riding` or `splash` visible after edge t+2.
- `logMoved` at edge t in RIDE → `push` (or `splash`) high for exactly the cycle after edge t+1.
- The frog controller must apply `push` within 1 cycle. `logMoved` spacing is ≥ 2 cycles, so `frogX` is current at the next test.
- `splash` is exactly 1 cycle wide and never asserts in the same cycle as `push`.
- `Reset` mid-ride: outputs are 0 after the reset edge, even if `logMoved` or `frogLanded` coincide with it.
- `respawn` and `Reset` have equal effect on outputs; `Reset` also clears the previous-`logX` register to 0.

## Structure
- A shared game package holds:
  - the state enum `rider_state_t` (IDLE, CHECK, RIDE, DEAD);
  - the lane constants `LANE_LEFT` = 143 and `LANE_RIGHT` = 431, shared with the log movers;
  - the default `FROG_W`.
- One sub-module, `span_hit`: combinational 11-bit overlap test with inputs `cx`, `left`, `len` and output `hit`. It is reused later by the car-collision block.
- The FSM, output registers and previous-`logX` register live in the top module.

## Test plan
- `logX`=200, `logY`=100, `frogY`=100, `frogX`=220, pulse `frogLanded` → `riding`=1 two cycles later; three `logMoved` strobes → exactly three one-cycle `push` pulses.
- Same setup with `frogX`=300 (cx=308 > 263) → `splash` one cycle wide two cycles after landing; `dead`=1 until `respawn`, then all outputs are 0.
- Riding, then `logX` goes from 432 to 143 with `logMoved` → `splash`, no `push`, `riding`=0.
- Riding with `frogX`=416 (416+16=432 > 431), `logMoved` → `splash`, no `push`.
- Riding, `frogHopping` and `logMoved` high in the same cycle → IDLE, `riding`=0, no `push`.
- Riding, assert `Reset` for one cycle together with `logMoved` → all outputs 0 after the edge; a following `logMoved` produces no `push`.

Source files
------------

// File: rtl/frog_log_rider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frog_log_rider_pkg
// Description : Shared game types and lane constants for the river lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package frog_log_rider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RIDE  = 2'd2,
        ST_DEAD  = 2'd3
    } rider_state_t;

    localparam int LANE_LEFT  = 143;
    localparam int LANE_RIGHT = 431;
    localparam int FROG_W     = 16;

endpackage
`default_nettype wire

// File: rtl/frog_log_rider_span_hit.sv
`default_nettype none
// ============================================================================
// Module      : span_hit
// Description : Combinational 11-bit test of whether cx lies in [left, left+len-1].
// Revision    : 1.0 - initial release
// ============================================================================
module span_hit (
    input  logic [10:0] cx,
    input  logic [10:0] left,
    input  logic [10:0] len,
    output logic        hit
);

    logic [10:0] w_right;

    assign w_right = left + len - 11'd1;
    assign hit     = (cx >= left) && (cx <= w_right);

endmodule
`default_nettype wire

// File: rtl/frog_log_rider.sv
`default_nettype none
// ============================================================================
// Module      : frog_log_rider
// Description : Decides whether a landed frog is on the log, then turns log
//               steps into push requests or signals a splash.
// Revision    : 1.0 - initial release
// ============================================================================
module frog_log_rider #(
    parameter int LOG_LEN    = 64,
    parameter int FROG_W     = frog_log_rider_pkg::FROG_W,
    parameter int LANE_RIGHT = frog_log_rider_pkg::LANE_RIGHT
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] logX,
    input  logic [9:0] logY,
    input  logic       logMoved,
    input  logic [9:0] frogX,
    input  logic [9:0] frogY,
    input  logic       frogLanded,
    input  logic       frogHopping,
    input  logic       respawn,
    output logic       push,
    output logic       riding,
    output logic       splash,
    output logic       dead
);

    import frog_log_rider_pkg::*;

    localparam logic [10:0] C_HALF_W  = 11'(FROG_W / 2);
    localparam logic [10:0] C_FROG_W  = 11'(FROG_W);
    localparam logic [10:0] C_LOG_LEN = 11'(LOG_LEN);
    localparam logic [10:0] C_LANE_R  = 11'(LANE_RIGHT);

    rider_state_t r_state;
    logic [9:0]   r_frog_x;
    logic [9:0]   r_log_x;
    logic [9:0]   r_prev_logx;

    logic [10:0]  w_cx;
    logic         w_on_log;
    logic         w_wrap;
    logic         w_off_lane;

    assign w_cx       = {1'b0, r_frog_x} + C_HALF_W;
    assign w_wrap     = (logX < r_prev_logx);
    assign w_off_lane = (({1'b0, frogX} + C_FROG_W) > C_LANE_R);

    span_hit u_span_hit (
        .cx   (w_cx),
        .left ({1'b0, r_log_x}),
        .len  (C_LOG_LEN),
        .hit  (w_on_log)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_frog_x    <= '0;
            r_log_x     <= '0;
            r_prev_logx <= '0;
            push        <= 1'b0;
            riding      <= 1'b0;
            splash      <= 1'b0;
            dead        <= 1'b0;
        end else begin
            push   <= 1'b0;
            splash <= 1'b0;
            if (logMoved) begin
                r_prev_logx <= logX;
            end

            if (respawn) begin
                r_state <= ST_IDLE;
                riding  <= 1'b0;
                dead    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (frogLanded && (frogY == logY)) begin
                            r_state  <= ST_CHECK;
                            r_frog_x <= frogX;
                            r_log_x  <= logX;
                        end
                    end
                    ST_CHECK: begin
                        if (w_on_log) begin
                            r_state <= ST_RIDE;
                            riding  <= 1'b1;
                        end else begin
                            r_state <= ST_DEAD;
                            splash  <= 1'b1;
                            dead    <= 1'b1;
                        end
                    end
                    ST_RIDE: begin
                        // A hop leaving the log beats any simultaneous log step.
                        if (frogHopping) begin
                            r_state <= ST_IDLE;
                            riding  <= 1'b0;
                        end else if (logMoved) begin
                            if (w_wrap || w_off_lane) begin
                                r_state <= ST_DEAD;
                                riding  <= 1'b0;
                                splash  <= 1'b1;
                                dead    <= 1'b1;
                            end else begin
                                push <= 1'b1;
                            end
                        end
                    end
                    ST_DEAD: begin
                        dead <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frog_log_rider.sv
`default_nettype none
// ============================================================================
// Module      : tb_frog_log_rider
// Description : Directed scoreboard bench for frog_log_rider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frog_log_rider;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] log_x, log_y, frog_x, frog_y;
    logic       log_moved, frog_landed, frog_hopping, respawn;
    logic       push, riding, splash, dead;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    frog_log_rider dut (
        .frame_clk   (clk),
        .Reset       (rst),
        .logX        (log_x),
        .logY        (log_y),
        .logMoved    (log_moved),
        .frogX       (frog_x),
        .frogY       (frog_y),
        .frogLanded  (frog_landed),
        .frogHopping (frog_hopping),
        .respawn     (respawn),
        .push        (push),
        .riding      (riding),
        .splash      (splash),
        .dead        (dead)
    );

    // One clock: drive strobes, queue the expected {push,riding,splash,dead}
    // after the edge, then compare.
    task automatic cyc(input logic lm, input logic fl, input logic fh,
                       input logic rs, input logic rr,
                       input logic [3:0] exp, input string tag);
        logic [3:0] got;
        logic [3:0] want;
        @(negedge clk);
        log_moved    = lm;
        frog_landed  = fl;
        frog_hopping = fh;
        respawn      = rs;
        rst          = rr;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got  = {push, riding, splash, dead};
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: {push,riding,splash,dead} got %b expected %b", tag, got, want);
        end
    endtask

    initial begin
        rst = 1'b1; log_moved = 0; frog_landed = 0; frog_hopping = 0; respawn = 0;
        log_x = 10'd200; log_y = 10'd100; frog_x = 10'd220; frog_y = 10'd100;

        cyc(0, 0, 0, 0, 1, 4'b0000, "reset");
        cyc(0, 0, 0, 0, 0, 4'b0000, "idle");

        // Land on the log, ride three steps, frog applies each push.
        cyc(0, 1, 0, 0, 0, 4'b0000, "land_check");
        cyc(0, 0, 0, 0, 0, 4'b0100, "riding_on");
        for (int i = 0; i < 3; i++) begin
            log_x = log_x + 10'd1;
            cyc(1, 0, 0, 0, 0, 4'b1100, "push_pulse");
            frog_x = frog_x + 10'd1;
            cyc(0, 0, 0, 0, 0, 4'b0100, "push_gap");
        end

        // Hop beats a coincident log step.
        log_x = 10'd204;
        cyc(1, 0, 1, 0, 0, 4'b0000, "hop_exit");
        cyc(0, 0, 0, 0, 0, 4'b0000, "hop_idle");

        // Landing on a different row is ignored.
        frog_y = 10'd120;
        cyc(0, 1, 0, 0, 0, 4'b0000, "wrong_row");
        cyc(0, 0, 0, 0, 0, 4'b0000, "wrong_row_idle");
        frog_y = 10'd100;

        // Miss: cx = 308 beyond log end 263.
        log_x = 10'd200; frog_x = 10'd300;
        cyc(0, 1, 0, 0, 0, 4'b0000, "miss_check");
        cyc(0, 0, 0, 0, 0, 4'b0011, "miss_splash");
        cyc(0, 0, 0, 0, 0, 4'b0001, "dead_hold");
        cyc(1, 0, 0, 0, 0, 4'b0001, "dead_ignores_move");
        cyc(0, 0, 0, 1, 0, 4'b0000, "respawn");
        cyc(0, 0, 0, 0, 0, 4'b0000, "after_respawn");

        // Boundary: cx = 263 is the last pixel of the log; then wrap kills.
        log_x = 10'd200; frog_x = 10'd255;
        cyc(0, 1, 0, 0, 0, 4'b0000, "edge_check");
        cyc(0, 0, 0, 0, 0, 4'b0100, "edge_riding");
        log_x = 10'd432;
        cyc(1, 0, 0, 0, 0, 4'b1100, "far_step");
        cyc(0, 0, 0, 0, 0, 4'b0100, "far_gap");
        log_x = 10'd143;
        cyc(1, 0, 0, 0, 0, 4'b0011, "wrap_splash");
        cyc(0, 0, 0, 0, 0, 4'b0001, "wrap_dead");
        cyc(0, 0, 0, 1, 0, 4'b0000, "wrap_respawn");

        // Lane edge: 415+16 = 431 still fits.
        log_x = 10'd400; frog_x = 10'd415;
        cyc(0, 1, 0, 0, 0, 4'b0000, "lane_ok_check");
        cyc(0, 0, 0, 0, 0, 4'b0100, "lane_ok_riding");
        log_x = 10'd401;
        cyc(1, 0, 0, 0, 0, 4'b1100, "lane_ok_push");
        cyc(0, 0, 1, 0, 0, 4'b0000, "lane_ok_hop");

        // Lane edge: 416+16 = 432 is carried off.
        log_x = 10'd400; frog_x = 10'd416;
        cyc(0, 1, 0, 0, 0, 4'b0000, "lane_off_check");
        cyc(0, 0, 0, 0, 0, 4'b0100, "lane_off_riding");
        log_x = 10'd401;
        cyc(1, 0, 0, 0, 0, 4'b0011, "lane_off_splash");
        cyc(0, 0, 0, 0, 0, 4'b0001, "lane_off_dead");
        cyc(0, 0, 0, 1, 0, 4'b0000, "lane_off_respawn");

        // Reset mid-ride coinciding with a log step.
        log_x = 10'd200; frog_x = 10'd220;
        cyc(0, 1, 0, 0, 0, 4'b0000, "rst_check");
        cyc(0, 0, 0, 0, 0, 4'b0100, "rst_riding");
        log_x = 10'd201;
        cyc(1, 0, 0, 0, 1, 4'b0000, "rst_with_move");
        log_x = 10'd202;
        cyc(1, 0, 0, 0, 0, 4'b0000, "move_after_rst");
        cyc(0, 0, 0, 0, 0, 4'b0000, "idle_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
